// File: rtl/accumulator.sv
// Neuron accumulate stage: sums N signed partial products per evaluation and forwards AF config packets.
// Optional feature macro: ACC_BIAS_EN (each evaluation starts from a configurable bias instead of zero).
module accumulator #(
  parameter  int NETWORK_SIZE = 256,
  localparam int SOURCE_WIDTH = $clog2(NETWORK_SIZE),
  // clog2(sqrt(N)*2), written with integer math on clog2(N)
  localparam int SEQ_WIDTH    = (SOURCE_WIDTH + 1) / 2 + 1,
  localparam int PAYLOAD_WIDTH = 32,
  localparam int TYPE_WIDTH    = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     MUL_ACC_valid,
  input  logic [TYPE_WIDTH-1:0]    MUL_ACC_type,
  input  logic [SEQ_WIDTH-1:0]     MUL_ACC_seqNum,
  input  logic [SOURCE_WIDTH-1:0]  MUL_ACC_inputNum,
  input  logic [PAYLOAD_WIDTH-1:0] MUL_ACC_data,
  output logic                     ACC_MUL_halt,
  input  logic                     ACC_AF_halt,
  output logic                     ACC_AF_valid,
  output logic [TYPE_WIDTH-1:0]    ACC_AF_type,
  output logic [SEQ_WIDTH-1:0]     ACC_AF_seqNum,
  output logic [PAYLOAD_WIDTH-1:0] ACC_AF_data,
  output logic                     ACC_err
);

  localparam int CNT_W = SOURCE_WIDTH + 1;

  localparam logic [TYPE_WIDTH-1:0] TYPE_DATA       = 3'b000;
  localparam logic [TYPE_WIDTH-1:0] TYPE_CONF_INB   = 3'b001;
  localparam logic [TYPE_WIDTH-1:0] TYPE_CONF_AFLUT = 3'b100;
  localparam logic [TYPE_WIDTH-1:0] TYPE_CONF_AFLB  = 3'b101;
  localparam logic [TYPE_WIDTH-1:0] TYPE_CONF_AFUB  = 3'b110;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACC  = 1'b1;

  logic [0:0]               state;
  logic [CNT_W-1:0]         cnt;
  logic [CNT_W-1:0]         num_inputs;
  logic [PAYLOAD_WIDTH-1:0] sum;
  logic [SEQ_WIDTH-1:0]     cur_seq;
  logic [PAYLOAD_WIDTH-1:0] init_val;

`ifdef ACC_BIAS_EN
  logic [PAYLOAD_WIDTH-1:0] bias;
  assign init_val = bias;
`else
  assign init_val = '0;
`endif

  logic                     accept;
  logic                     seq_err;
  logic [PAYLOAD_WIDTH-1:0] base;
  logic [PAYLOAD_WIDTH:0]   sum_wide;
  logic [PAYLOAD_WIDTH-1:0] sat_sum;
  logic [CNT_W-1:0]         cnt_next;
  logic                     complete;

  assign ACC_MUL_halt = ACC_AF_valid & ACC_AF_halt;
  assign accept       = MUL_ACC_valid & ~ACC_MUL_halt;
  assign seq_err      = (state == ACC) && (MUL_ACC_seqNum != cur_seq);

  // A new evaluation (from IDLE or after a sequence error) starts from init; otherwise continue the running sum.
  always_comb begin
    base     = ((state == ACC) && !seq_err) ? sum : init_val;
    sum_wide = {base[PAYLOAD_WIDTH-1], base} + {MUL_ACC_data[PAYLOAD_WIDTH-1], MUL_ACC_data};
    sat_sum  = sum_wide[PAYLOAD_WIDTH-1:0];
    if (sum_wide[PAYLOAD_WIDTH] != sum_wide[PAYLOAD_WIDTH-1])
      sat_sum = sum_wide[PAYLOAD_WIDTH] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    cnt_next = ((state == ACC) && !seq_err) ? cnt + CNT_W'(1) : CNT_W'(1);
    complete = (num_inputs != '0) && (cnt_next == num_inputs);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      num_inputs    <= '0;
      sum           <= '0;
      cur_seq       <= '0;
`ifdef ACC_BIAS_EN
      bias          <= '0;
`endif
      ACC_AF_valid  <= 1'b0;
      ACC_AF_type   <= '0;
      ACC_AF_seqNum <= '0;
      ACC_AF_data   <= '0;
      ACC_err       <= 1'b0;
    end else begin
      ACC_err <= 1'b0;
      if (ACC_AF_valid && !ACC_AF_halt)
        ACC_AF_valid <= 1'b0;
      if (accept) begin
        case (MUL_ACC_type)
          TYPE_DATA: begin
            if (seq_err)
              ACC_err <= 1'b1;
            if (complete) begin
              ACC_AF_valid  <= 1'b1;
              ACC_AF_type   <= TYPE_DATA;
              ACC_AF_seqNum <= MUL_ACC_seqNum;
              ACC_AF_data   <= sat_sum;
              sum           <= '0;
              cnt           <= '0;
              state         <= IDLE;
            end else begin
              sum     <= sat_sum;
              cnt     <= cnt_next;
              cur_seq <= MUL_ACC_seqNum;
              state   <= ACC;
            end
          end
          TYPE_CONF_INB: begin
            if (MUL_ACC_inputNum == '0)
              num_inputs <= MUL_ACC_data[SOURCE_WIDTH:0];
`ifdef ACC_BIAS_EN
            else if (MUL_ACC_inputNum == SOURCE_WIDTH'(1))
              bias <= MUL_ACC_data;
`endif
            sum   <= '0;
            cnt   <= '0;
            state <= IDLE;
          end
          TYPE_CONF_AFLUT, TYPE_CONF_AFLB, TYPE_CONF_AFUB: begin
            ACC_AF_valid  <= 1'b1;
            ACC_AF_type   <= MUL_ACC_type;
            ACC_AF_seqNum <= MUL_ACC_seqNum;
            ACC_AF_data   <= MUL_ACC_data;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_accumulator.sv
// Directed testbench for accumulator: sums, saturation, sequence errors, stalls, passthrough, bias and reset.
module tb_accumulator;

  logic        clk;
  logic        rst;
  logic        MUL_ACC_valid;
  logic [2:0]  MUL_ACC_type;
  logic [4:0]  MUL_ACC_seqNum;
  logic [7:0]  MUL_ACC_inputNum;
  logic [31:0] MUL_ACC_data;
  logic        ACC_MUL_halt;
  logic        ACC_AF_halt;
  logic        ACC_AF_valid;
  logic [2:0]  ACC_AF_type;
  logic [4:0]  ACC_AF_seqNum;
  logic [31:0] ACC_AF_data;
  logic        ACC_err;

  int compared;
  int mismatched;

  localparam logic [2:0] T_DATA = 3'b000;
  localparam logic [2:0] T_INB  = 3'b001;
  localparam logic [2:0] T_W    = 3'b010;
  localparam logic [2:0] T_AFLB = 3'b101;

  accumulator dut (
    .clk(clk), .rst(rst),
    .MUL_ACC_valid(MUL_ACC_valid), .MUL_ACC_type(MUL_ACC_type), .MUL_ACC_seqNum(MUL_ACC_seqNum),
    .MUL_ACC_inputNum(MUL_ACC_inputNum), .MUL_ACC_data(MUL_ACC_data), .ACC_MUL_halt(ACC_MUL_halt),
    .ACC_AF_halt(ACC_AF_halt), .ACC_AF_valid(ACC_AF_valid), .ACC_AF_type(ACC_AF_type),
    .ACC_AF_seqNum(ACC_AF_seqNum), .ACC_AF_data(ACC_AF_data), .ACC_err(ACC_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one packet for exactly one accepting edge, then sample 1 ns after that edge.
  task automatic send(input logic [2:0] t, input logic [4:0] s, input logic [7:0] n, input logic [31:0] d);
    int w;
    w = 0;
    while (ACC_MUL_halt && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    compared++;
    if (ACC_MUL_halt !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL send_halt_timeout: halt=%b required 0", ACC_MUL_halt);
    end
    MUL_ACC_valid = 1'b1; MUL_ACC_type = t; MUL_ACC_seqNum = s; MUL_ACC_inputNum = n; MUL_ACC_data = d;
    @(posedge clk); #1;
    MUL_ACC_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    compared++;
    if ({ACC_AF_valid, ACC_AF_type, ACC_AF_seqNum, ACC_AF_data, ACC_err, ACC_MUL_halt} !== 43'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got %h required 0",
               {ACC_AF_valid, ACC_AF_type, ACC_AF_seqNum, ACC_AF_data, ACC_err, ACC_MUL_halt});
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sum();
    send(T_INB, 5'd0, 8'd0, 32'd4);
    send(T_DATA, 5'd2, 8'd0, 32'd10);
    send(T_DATA, 5'd2, 8'd1, 32'd20);
    send(T_DATA, 5'd2, 8'd2, 32'hFFFF_FFFB);
    compared++;
    if (ACC_AF_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL sum_early_valid: got %b required 0", ACC_AF_valid);
    end
    send(T_DATA, 5'd2, 8'd3, 32'd7);
    compared++;
    if ({ACC_AF_valid, ACC_AF_type, ACC_AF_seqNum, ACC_AF_data} !== {1'b1, T_DATA, 5'd2, 32'd32}) begin
      mismatched++;
      $display("[TB] FAIL sum_out: got %h required %h",
               {ACC_AF_valid, ACC_AF_type, ACC_AF_seqNum, ACC_AF_data}, {1'b1, T_DATA, 5'd2, 32'd32});
    end
    @(posedge clk); #1;
    compared++;
    if (ACC_AF_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL sum_valid_drop: got %b required 0", ACC_AF_valid);
    end
  endtask

  task automatic test_saturation();
    send(T_INB, 5'd0, 8'd0, 32'd2);
    send(T_DATA, 5'd1, 8'd0, 32'h7FFF_FFF0);
    send(T_DATA, 5'd1, 8'd1, 32'h0000_0100);
    compared++;
    if (ACC_AF_data !== 32'h7FFF_FFFF || ACC_AF_valid !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL sat_pos: got %b/%h required 1/7fffffff", ACC_AF_valid, ACC_AF_data);
    end
    send(T_DATA, 5'd1, 8'd0, 32'h8000_0010);
    send(T_DATA, 5'd1, 8'd1, 32'hFFFF_FF00);
    compared++;
    if (ACC_AF_data !== 32'h8000_0000 || ACC_AF_valid !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL sat_neg: got %b/%h required 1/80000000", ACC_AF_valid, ACC_AF_data);
    end
    send(T_INB, 5'd0, 8'd0, 32'd3);
    send(T_DATA, 5'd1, 8'd0, 32'h7FFF_FFF0);
    send(T_DATA, 5'd1, 8'd1, 32'h0000_0100);
    send(T_DATA, 5'd1, 8'd2, 32'hFFFF_FFFF);
    compared++;
    if (ACC_AF_data !== 32'h7FFF_FFFE || ACC_AF_valid !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL sat_sticky: got %b/%h required 1/7ffffffe", ACC_AF_valid, ACC_AF_data);
    end
  endtask

  task automatic test_seq_error();
    send(T_INB, 5'd0, 8'd0, 32'd3);
    send(T_DATA, 5'd1, 8'd0, 32'd5);
    send(T_DATA, 5'd1, 8'd1, 32'd6);
    compared++;
    if (ACC_err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL seq_no_err: got %b required 0", ACC_err);
    end
    send(T_DATA, 5'd3, 8'd0, 32'd9);
    compared++;
    if ({ACC_err, ACC_AF_valid} !== 2'b10) begin
      mismatched++;
      $display("[TB] FAIL seq_err_pulse: got err,valid=%b required 10", {ACC_err, ACC_AF_valid});
    end
    send(T_DATA, 5'd3, 8'd1, 32'd1);
    compared++;
    if ({ACC_err, ACC_AF_valid} !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL seq_err_clear: got err,valid=%b required 00", {ACC_err, ACC_AF_valid});
    end
    send(T_DATA, 5'd3, 8'd2, 32'd1);
    compared++;
    if ({ACC_AF_valid, ACC_AF_type, ACC_AF_seqNum, ACC_AF_data} !== {1'b1, T_DATA, 5'd3, 32'd11}) begin
      mismatched++;
      $display("[TB] FAIL seq_restart_out: got %h required %h",
               {ACC_AF_valid, ACC_AF_type, ACC_AF_seqNum, ACC_AF_data}, {1'b1, T_DATA, 5'd3, 32'd11});
    end
  endtask

  task automatic test_back_pressure();
    send(T_INB, 5'd0, 8'd0, 32'd1);
    send(T_DATA, 5'd4, 8'd0, 32'd42);
    ACC_AF_halt = 1'b1;
    MUL_ACC_valid = 1'b1; MUL_ACC_type = T_DATA; MUL_ACC_seqNum = 5'd5; MUL_ACC_inputNum = 8'd0;
    MUL_ACC_data = 32'd77;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      compared++;
      if ({ACC_MUL_halt, ACC_AF_valid, ACC_AF_seqNum, ACC_AF_data} !== {1'b1, 1'b1, 5'd4, 32'd42}) begin
        mismatched++;
        $display("[TB] FAIL halt_hold[%0d]: got %h required %h", i,
                 {ACC_MUL_halt, ACC_AF_valid, ACC_AF_seqNum, ACC_AF_data}, {1'b1, 1'b1, 5'd4, 32'd42});
      end
    end
    ACC_AF_halt = 1'b0;
    @(posedge clk); #1;
    MUL_ACC_valid = 1'b0;
    compared++;
    if ({ACC_MUL_halt, ACC_AF_valid, ACC_AF_seqNum, ACC_AF_data} !== {1'b0, 1'b1, 5'd5, 32'd77}) begin
      mismatched++;
      $display("[TB] FAIL halt_release: got %h required %h",
               {ACC_MUL_halt, ACC_AF_valid, ACC_AF_seqNum, ACC_AF_data}, {1'b0, 1'b1, 5'd5, 32'd77});
    end
    @(posedge clk); #1;
    compared++;
    if (ACC_AF_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL halt_drain: got %b required 0", ACC_AF_valid);
    end
  endtask

  task automatic test_passthrough();
    send(T_INB, 5'd0, 8'd0, 32'd3);
    send(T_DATA, 5'd6, 8'd0, 32'd1);
    send(T_DATA, 5'd6, 8'd1, 32'd2);
    send(T_AFLB, 5'd7, 8'd3, 32'hDEAD_0001);
    compared++;
    if ({ACC_AF_valid, ACC_AF_type, ACC_AF_seqNum, ACC_AF_data} !== {1'b1, T_AFLB, 5'd7, 32'hDEAD_0001}) begin
      mismatched++;
      $display("[TB] FAIL pass_aflb: got %h required %h",
               {ACC_AF_valid, ACC_AF_type, ACC_AF_seqNum, ACC_AF_data}, {1'b1, T_AFLB, 5'd7, 32'hDEAD_0001});
    end
    send(T_W, 5'd7, 8'd0, 32'd5);
    compared++;
    if (ACC_AF_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL drop_confw: got %b required 0", ACC_AF_valid);
    end
    send(T_DATA, 5'd6, 8'd2, 32'd3);
    compared++;
    if ({ACC_AF_valid, ACC_AF_type, ACC_AF_seqNum, ACC_AF_data} !== {1'b1, T_DATA, 5'd6, 32'd6}) begin
      mismatched++;
      $display("[TB] FAIL pass_final_sum: got %h required %h",
               {ACC_AF_valid, ACC_AF_type, ACC_AF_seqNum, ACC_AF_data}, {1'b1, T_DATA, 5'd6, 32'd6});
    end
  endtask

  task automatic test_bias_and_reset();
    logic [31:0] exp_sum;
`ifdef ACC_BIAS_EN
    exp_sum = 32'd103;
`else
    exp_sum = 32'd3;
`endif
    send(T_INB, 5'd0, 8'd0, 32'd2);
    send(T_INB, 5'd0, 8'd1, 32'd100);
    send(T_DATA, 5'd8, 8'd0, 32'd1);
    send(T_DATA, 5'd8, 8'd1, 32'd2);
    compared++;
    if (ACC_AF_data !== exp_sum || ACC_AF_valid !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL bias_sum: got %b/%0d required 1/%0d", ACC_AF_valid, ACC_AF_data, exp_sum);
    end
    ACC_AF_halt = 1'b1;
    send(T_DATA, 5'd9, 8'd0, 32'd9);
    #2 rst = 1'b0;
    #1;
    compared++;
    if ({ACC_AF_valid, ACC_AF_type, ACC_AF_seqNum, ACC_AF_data, ACC_err, ACC_MUL_halt} !== 43'd0) begin
      mismatched++;
      $display("[TB] FAIL async_reset: got %h required 0",
               {ACC_AF_valid, ACC_AF_type, ACC_AF_seqNum, ACC_AF_data, ACC_err, ACC_MUL_halt});
    end
    ACC_AF_halt = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    send(T_DATA, 5'd1, 8'd0, 32'd4);
    send(T_DATA, 5'd1, 8'd1, 32'd4);
    compared++;
    if (ACC_AF_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL config_lost: got %b required 0", ACC_AF_valid);
    end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    rst = 1'b0;
    MUL_ACC_valid = 1'b0; MUL_ACC_type = '0; MUL_ACC_seqNum = '0; MUL_ACC_inputNum = '0; MUL_ACC_data = '0;
    ACC_AF_halt = 1'b0;
    test_reset();
    test_sum();
    test_saturation();
    test_seq_error();
    test_back_pressure();
    test_passthrough();
    test_bias_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
